mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types.sv | 23 ++
 rtl/mem_arb_select.sv | 45 ++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types.sv
// Shared CPU-side types: memory arbiter state, requester identity and the
// latched access record driven onto the RAM port.
package cpu_types;

  typedef enum logic {
    IDLE,
    ACCESS
  } arb_state_t;

  typedef enum logic {
    REQ_FETCH,
    REQ_DATA
  } mem_requester_t;

  typedef struct packed {
    mem_requester_t owner;
    logic [31:0]    addr;
    logic           we;
    logic [31:0]    wdata;
    logic [3:0]     byte_enable;
  } mem_access_t;

endpackage

// File: rtl/mem_arb_select.sv
// Grant selection between fetch and data requesters: data has fixed priority
// unless the fetch has waited through STARVE_LIMIT consecutive data grants.
module mem_arb_select #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_valid,
  input  logic d_req_valid,
  output logic if_req_ready,
  output logic d_req_ready,
  output logic if_grant,
  output logic d_grant
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == LIMIT);

  // Each ready looks only at the other requester's valid, so neither handshake
  // loops combinationally through its own valid.
  always_comb begin
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    if (!rst) begin
      if_req_ready = !d_req_valid || starved;
      d_req_ready  = !(starved && if_req_valid);
    end
    if_grant = if_req_valid && if_req_ready;
    d_grant  = d_req_valid && d_req_ready;
  end

  always_ff @(posedge clk) begin
    if (rst || !if_req_valid || if_grant) begin
      starve_cnt <= '0;
    end else if (d_grant && !starved) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch and data accesses. One
// request is latched per cycle and presented to the RAM the following cycle.
module mem_arbiter
  import cpu_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_enable,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic [31:0] memory_address,
  output logic [31:0] memory_write,
  output logic [3:0]  memory_byte_enable,
  output logic        memory_we,
  input  logic [31:0] memory_out
);

  arb_state_t  state_q, state_d;
  mem_access_t acc_q, acc_d;
  logic        if_grant, d_grant;
  logic        active;
  logic [31:0] if_hold, d_hold;

  mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .d_req_valid  (d_req_valid),
    .if_req_ready (if_req_ready),
    .d_req_ready  (d_req_ready),
    .if_grant     (if_grant),
    .d_grant      (d_grant)
  );

  // A fetch leaves wdata untouched so memory_write keeps its last value.
  always_comb begin
    acc_d   = acc_q;
    state_d = IDLE;
    if (if_grant) begin
      acc_d.owner       = REQ_FETCH;
      acc_d.addr        = if_addr & ~32'h3;
      acc_d.we          = 1'b0;
      acc_d.byte_enable = '0;
      state_d           = ACCESS;
    end else if (d_grant) begin
      acc_d.owner       = REQ_DATA;
      acc_d.addr        = d_addr & ~32'h3;
      acc_d.we          = d_we;
      acc_d.wdata       = d_wdata;
      acc_d.byte_enable = d_we ? d_byte_enable : '0;
      state_d           = ACCESS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      if_hold <= '0;
      d_hold  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (if_rsp_valid) if_hold <= if_rsp_data;
      if (d_rsp_valid)  d_hold  <= d_rsp_data;
    end
  end

  // rst gates the live access so a write caught by reset never commits.
  always_comb begin
    active             = !rst && (state_q == ACCESS);
    memory_address     = rst ? '0 : acc_q.addr;
    memory_write       = rst ? '0 : acc_q.wdata;
    memory_we          = active && acc_q.we;
    memory_byte_enable = active ? acc_q.byte_enable : '0;
    if_rsp_valid       = active && (acc_q.owner == REQ_FETCH);
    d_rsp_valid        = active && (acc_q.owner == REQ_DATA);
    if_rsp_data        = rst ? '0 : (if_rsp_valid ? memory_out : if_hold);
    d_rsp_data         = d_hold;
    if (rst) begin
      d_rsp_data = '0;
    end else if (d_rsp_valid) begin
      d_rsp_data = acc_q.we ? '0 : memory_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM.
module tb_mem_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic [3:0]  d_byte_enable;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic [31:0] memory_address;
  logic [31:0] memory_write;
  logic [3:0]  memory_byte_enable;
  logic        memory_we;
  logic [31:0] memory_out;

  logic [31:0] ram [0:63];
  int checks = 0;
  int errors = 0;
  logic [31:0] if_hold_exp;

  mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .if_req_valid       (if_req_valid),
    .if_req_ready       (if_req_ready),
    .if_addr            (if_addr),
    .if_rsp_valid       (if_rsp_valid),
    .if_rsp_data        (if_rsp_data),
    .d_req_valid        (d_req_valid),
    .d_req_ready        (d_req_ready),
    .d_addr             (d_addr),
    .d_we               (d_we),
    .d_wdata            (d_wdata),
    .d_byte_enable      (d_byte_enable),
    .d_rsp_valid        (d_rsp_valid),
    .d_rsp_data         (d_rsp_data),
    .memory_address     (memory_address),
    .memory_write       (memory_write),
    .memory_byte_enable (memory_byte_enable),
    .memory_we          (memory_we),
    .memory_out         (memory_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign memory_out = ram[memory_address[7:2]];

  always @(posedge clk) begin
    if (memory_we) begin
      for (int b = 0; b < 4; b++) begin
        if (memory_byte_enable[b]) ram[memory_address[7:2]][8*b +: 8] <= memory_write[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp);
    tick();
    if_req_valid = 1'b1;
    if_addr      = addr;
    #1;
    check("fetch_ready", if_req_ready, 1);
    tick();
    if_req_valid = 1'b0;
    #1;
    check("fetch_rsp_valid", if_rsp_valid, 1);
    check("fetch_rsp_data", if_rsp_data, exp);
    check("fetch_d_rsp_valid", d_rsp_valid, 0);
    check("fetch_mem_we", memory_we, 0);
    check("fetch_mem_be", memory_byte_enable, 0);
    check("fetch_mem_addr", memory_address, addr & ~32'h3);
    if_hold_exp = exp;
    tick();
    #1;
    check("fetch_idle_rsp_valid", if_rsp_valid, 0);
    check("fetch_idle_mem_we", memory_we, 0);
    check("fetch_idle_rsp_hold", if_rsp_data, exp);
  endtask

  task automatic do_data(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp);
    tick();
    d_req_valid   = 1'b1;
    d_addr        = addr;
    d_we          = we;
    d_wdata       = wdata;
    d_byte_enable = be;
    #1;
    check("data_ready", d_req_ready, 1);
    tick();
    d_req_valid = 1'b0;
    d_we        = 1'b0;
    #1;
    check("data_rsp_valid", d_rsp_valid, 1);
    check("data_rsp_data", d_rsp_data, exp);
    check("data_if_rsp_valid", if_rsp_valid, 0);
    check("data_if_rsp_hold", if_rsp_data, if_hold_exp);
    check("data_mem_we", memory_we, we);
    check("data_mem_be", memory_byte_enable, we ? be : 4'b0000);
    check("data_mem_addr", memory_address, addr & ~32'h3);
    if (we) check("data_mem_write", memory_write, wdata);
    tick();
    #1;
    check("data_idle_rsp_valid", d_rsp_valid, 0);
    check("data_idle_mem_we", memory_we, 0);
    check("data_idle_mem_be", memory_byte_enable, 0);
    check("data_idle_addr_hold", memory_address, addr & ~32'h3);
    check("data_idle_rsp_hold", d_rsp_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic is_f, prev_f;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[1] = 32'h11223344;
    ram[2] = 32'h00200113;
    ram[4] = 32'hDEADBEEF;
    if_hold_exp = 32'h0;

    // Both requests pending through reset.
    rst           = 1'b1;
    if_req_valid  = 1'b1;
    if_addr       = 32'h8;
    d_req_valid   = 1'b1;
    d_addr        = 32'h8;
    d_we          = 1'b0;
    d_wdata       = 32'h0;
    d_byte_enable = 4'h0;
    repeat (3) tick();
    #1;
    check("rst_if_ready", if_req_ready, 0);
    check("rst_d_ready", d_req_ready, 0);
    check("rst_if_rsp_valid", if_rsp_valid, 0);
    check("rst_d_rsp_valid", d_rsp_valid, 0);
    check("rst_mem_we", memory_we, 0);
    check("rst_mem_be", memory_byte_enable, 0);
    check("rst_mem_addr", memory_address, 0);
    check("rst_mem_write", memory_write, 0);
    check("rst_if_rsp_data", if_rsp_data, 0);
    check("rst_d_rsp_data", d_rsp_data, 0);

    // Starvation pattern D,D,D,D,F repeated, starting fresh after reset.
    tick();
    rst    = 1'b0;
    prev_f = 1'b0;
    for (int i = 0; i < 10; i++) begin
      is_f = (i % 5 == 4);
      #1;
      check($sformatf("starve_d_ready_%0d", i), d_req_ready, !is_f);
      check($sformatf("starve_if_ready_%0d", i), if_req_ready, is_f);
      if (i > 0) begin
        check($sformatf("starve_if_rsp_%0d", i), if_rsp_valid, prev_f);
        check($sformatf("starve_d_rsp_%0d", i), d_rsp_valid, !prev_f);
        if (prev_f) check($sformatf("starve_if_data_%0d", i), if_rsp_data, 32'h00200113);
        else        check($sformatf("starve_d_data_%0d", i), d_rsp_data, 32'h00200113);
      end
      prev_f = is_f;
      tick();
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    #1;
    check("starve_last_if_rsp", if_rsp_valid, 1);
    check("starve_last_d_rsp", d_rsp_valid, 0);
    if_hold_exp = 32'h00200113;
    tick();
    #1;
    check("starve_idle_if_rsp", if_rsp_valid, 0);
    check("starve_idle_mem_we", memory_we, 0);

    do_fetch(32'h8, 32'h00200113);

    do_data(32'h6, 1'b1, 32'h00FF0000, 4'b0100, 32'h0);
    do_data(32'h4, 1'b0, 32'h0, 4'b0000, 32'h11FF3344);

    // Back-to-back write then read of the same word.
    tick();
    d_req_valid   = 1'b1;
    d_we          = 1'b1;
    d_addr        = 32'h4;
    d_wdata       = 32'h0000000A;
    d_byte_enable = 4'b1111;
    #1;
    check("b2b_wr_ready", d_req_ready, 1);
    tick();
    d_we = 1'b0;
    #1;
    check("b2b_wr_rsp_valid", d_rsp_valid, 1);
    check("b2b_wr_rsp_data", d_rsp_data, 0);
    check("b2b_wr_mem_we", memory_we, 1);
    check("b2b_rd_ready", d_req_ready, 1);
    tick();
    d_req_valid = 1'b0;
    #1;
    check("b2b_rd_rsp_valid", d_rsp_valid, 1);
    check("b2b_rd_rsp_data", d_rsp_data, 32'h0000000A);
    check("b2b_rd_mem_we", memory_we, 0);
    tick();
    #1;
    check("b2b_idle_rsp_valid", d_rsp_valid, 0);

    // Alternating single requests with idle gaps; low address bits ignored.
    do_fetch(32'hB, 32'h00200113);
    do_data(32'h7, 1'b0, 32'h0, 4'b0000, 32'h0000000A);
    do_fetch(32'h9, 32'h00200113);

    // Reset during the ACCESS cycle of a write cancels it.
    tick();
    d_req_valid   = 1'b1;
    d_we          = 1'b1;
    d_addr        = 32'h10;
    d_wdata       = 32'h12345678;
    d_byte_enable = 4'b1111;
    #1;
    check("rstwr_ready", d_req_ready, 1);
    tick();
    d_req_valid = 1'b0;
    d_we        = 1'b0;
    rst         = 1'b1;
    #1;
    check("rstwr_mem_we", memory_we, 0);
    check("rstwr_d_rsp_valid", d_rsp_valid, 0);
    check("rstwr_d_ready", d_req_ready, 0);
    check("rstwr_mem_addr", memory_address, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rstwr_after_rsp", d_rsp_valid, 0);
    check("rstwr_ram_word", ram[4], 32'hDEADBEEF);
    tick();
    #1;
    check("rstwr_after2_rsp", d_rsp_valid, 0);
    check("rstwr_if_data_cleared", if_rsp_data, 0);
    if_hold_exp = 32'h0;
    do_data(32'h10, 1'b0, 32'h0, 4'b0000, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
